mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory stage: funct3 load/store
// encodings, FSM states, alignment and store-strobe rules.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Only funct3[1:0] carries the access size; bit 2 is the unsigned flag.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == F3_LH[1:0]) && a[0]) ||
               ((f3[1:0] == F3_LW[1:0]) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_SB:   return 4'b0001 << a;
            F3_SH:   return 4'b0011 << a;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shift the addressed byte/halfword down to bit 0,
// then sign- or zero-extend according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = rdata >> {a, 3'b000};

    always_comb begin
        data = sh;
        case (funct3)
            F3_LB:   data = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   data = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  data = {24'd0, sh[7:0]};
            F3_LHU:  data = {16'd0, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: stage register plus a single-outstanding bus access FSM
// that stalls upstream while a load/store is in flight.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_clear,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] EX_result,
    input  logic [31:0] rs2_value,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        R_wen,
    input  logic        mem_wen,
    input  logic        mem_ren,
    input  logic [3:0]  csr_wen,
    input  logic [31:0] csrs,
    output logic        mem_stall,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic [31:0] pc_next,
    output logic [31:0] inst_next,
    output logic [31:0] csrs_next,
    output logic [4:0]  rd_next,
    output logic [3:0]  csr_wen_next,
    output logic        R_wen_next,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t      state, state_nx;
    logic [CW-1:0] cnt;

    logic [31:0] pc_r, inst_r, ex_r, rs2_r, csrs_r, ld_r;
    logic [4:0]  rd_r;
    logic [2:0]  f3_r;
    logic [3:0]  csr_wen_r;
    logic        rwen_r, mwen_r, mren_r, mis_r, err_r;

    logic        stall, cap_mem, cap_mis, to_hit, latch_ld, err_set;
    logic [31:0] ld_data;

    assign stall   = (state == S_REQ) || (state == S_WAIT);
    assign cap_mem = !inst_clear && (mem_ren || mem_wen);
    assign cap_mis = cap_mem && misaligned(funct3, EX_result[1:0]);
    assign to_hit  = (cnt == CW'(MEM_TIMEOUT - 1));

    load_align u_align (
        .rdata  (resp_rdata),
        .a      (ex_r[1:0]),
        .funct3 (f3_r),
        .data   (ld_data)
    );

    // A response arriving on the timeout cycle still wins in WAIT.
    always_comb begin
        state_nx = state;
        latch_ld = 1'b0;
        err_set  = 1'b0;
        case (state)
            S_IDLE, S_DONE: state_nx = (cap_mem && !cap_mis) ? S_REQ : S_IDLE;
            S_REQ: begin
                if (to_hit) begin
                    state_nx = S_DONE;
                    err_set  = 1'b1;
                end else if (req_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    state_nx = S_DONE;
                    latch_ld = 1'b1;
                end else if (to_hit) begin
                    state_nx = S_DONE;
                    err_set  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pc_r      <= '0;
            inst_r    <= '0;
            ex_r      <= '0;
            rs2_r     <= '0;
            csrs_r    <= '0;
            ld_r      <= '0;
            rd_r      <= '0;
            f3_r      <= '0;
            csr_wen_r <= '0;
            rwen_r    <= 1'b0;
            mwen_r    <= 1'b0;
            mren_r    <= 1'b0;
            mis_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= stall ? cnt + 1'b1 : '0;
            err_r <= err_set;
            if (!stall) begin
                pc_r      <= pc;
                inst_r    <= inst;
                ex_r      <= EX_result;
                rs2_r     <= rs2_value;
                csrs_r    <= csrs;
                rd_r      <= rd;
                f3_r      <= funct3;
                rwen_r    <= R_wen && !inst_clear;
                mwen_r    <= mem_wen && !inst_clear;
                mren_r    <= mem_ren && !inst_clear;
                csr_wen_r <= inst_clear ? 4'd0 : csr_wen;
                mis_r     <= cap_mis;
                ld_r      <= '0;
            end
            if (latch_ld && mren_r)
                ld_r <= ld_data;
        end
    end

    assign mem_stall    = stall;
    assign req_valid    = (state == S_REQ);
    assign req_addr     = req_valid ? {ex_r[31:2], 2'b00} : 32'd0;
    assign req_wen      = req_valid && mwen_r;
    assign req_wstrb    = (req_valid && mwen_r) ? store_strb(f3_r, ex_r[1:0]) : 4'd0;
    assign req_wdata    = req_valid ? (rs2_r << {ex_r[1:0], 3'b000}) : 32'd0;

    assign pc_next      = pc_r;
    assign inst_next    = inst_r;
    assign csrs_next    = csrs_r;
    assign rd_next      = rd_r;
    assign csr_wen_next = stall ? 4'd0 : csr_wen_r;
    assign R_wen_next   = rwen_r && !stall && !mis_r && !err_r;
    assign wb_data      = mren_r ? ld_r : ex_r;
    assign misalign     = mis_r;
    assign bus_err      = err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-instruction outcome model plus a bus
// responder, with one negedge compare process.
module tb_mem_stage;

    localparam int TO = 8;
    localparam int N  = 17;

    logic        clk, rst, inst_clear;
    logic [31:0] pc, inst, EX_result, rs2_value, csrs;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        R_wen, mem_wen, mem_ren;
    logic [3:0]  csr_wen;
    logic        mem_stall, req_valid, req_ready, req_wen, resp_valid;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;
    logic [31:0] pc_next, inst_next, csrs_next, wb_data;
    logic [4:0]  rd_next;
    logic [3:0]  csr_wen_next;
    logic        R_wen_next, misalign, bus_err;

    mem_stage #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .inst_clear(inst_clear), .pc(pc), .inst(inst),
        .EX_result(EX_result), .rs2_value(rs2_value), .rd(rd), .funct3(funct3),
        .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren), .csr_wen(csr_wen),
        .csrs(csrs), .mem_stall(mem_stall), .req_valid(req_valid),
        .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .pc_next(pc_next), .inst_next(inst_next),
        .csrs_next(csrs_next), .rd_next(rd_next), .csr_wen_next(csr_wen_next),
        .R_wen_next(R_wen_next), .wb_data(wb_data), .misalign(misalign),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst, ex, rs2, csrs, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rwen, mwen, mren, clr, clr_stall;
        logic [3:0]  csr_wen;
        int          rdy, rsp;
        logic        lit_en;
        logic [31:0] lit_wb, lit_addr, lit_wdata;
        logic [3:0]  lit_strb;
    } vec_t;

    typedef struct {
        logic [31:0] wb, addr, wdata;
        logic [3:0]  strb;
        logic        rwen, mis, err, wbchk, store;
        int          stalls;
    } exp_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } ent_t;

    vec_t vecs[N];
    vec_t cur, bub;
    ent_t q[$];
    int   tests = 0, fails = 0, cyc = 0, stall_run = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [vec %0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic rw, mw, mr,
                                input logic [31:0] ex, rs2, rdata, input int rdy, rsp);
        vec_t v;
        v = '{default: 0};
        v.f3 = f3; v.rwen = rw; v.mwen = mw; v.mren = mr;
        v.ex = ex; v.rs2 = rs2; v.rdata = rdata; v.rdy = rdy; v.rsp = rsp;
        return v;
    endfunction

    // Outcome of one instruction, stated from the rules rather than the FSM.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic mem;
        logic [1:0] a;
        logic [31:0] sh;
        e = '{default: 0};
        a = v.ex[1:0];
        mem = !v.clr && (v.mren || v.mwen);
        e.store = !v.clr && v.mwen;
        e.mis = mem && ((v.f3[1:0] == 2'd1 && a[0]) || (v.f3[1:0] == 2'd2 && a != 2'd0));
        e.err = mem && !e.mis && (v.rsp < 0 || v.rdy + v.rsp + 2 > TO);
        e.stalls = (!mem || e.mis) ? 0 : (e.err ? TO : v.rdy + v.rsp + 2);
        e.rwen = !v.clr && v.rwen && !e.mis && !e.err;
        e.addr = v.ex & 32'hFFFF_FFFC;
        e.wdata = v.rs2 << (8 * a);
        case (v.f3[1:0])
            2'd0:    e.strb = 4'b0001 << a;
            2'd1:    e.strb = 4'b0011 << a;
            default: e.strb = 4'b1111;
        endcase
        sh = v.rdata >> (8 * a);
        e.wbchk = 1'b1;
        if (!v.clr && v.mren) begin
            if (e.mis || e.err) e.wbchk = 1'b0;
            else case (v.f3)
                3'b000:  e.wb = 32'($signed(sh[7:0]));
                3'b001:  e.wb = 32'($signed(sh[15:0]));
                3'b100:  e.wb = {24'd0, sh[7:0]};
                3'b101:  e.wb = {16'd0, sh[15:0]};
                default: e.wb = sh;
            endcase
        end else begin
            e.wb = v.ex;
        end
        return e;
    endfunction

    task automatic apply(input vec_t v);
        pc = v.pc; inst = v.inst; EX_result = v.ex; rs2_value = v.rs2;
        rd = v.rd; funct3 = v.f3; R_wen = v.rwen; mem_wen = v.mwen;
        mem_ren = v.mren; csr_wen = v.csr_wen; csrs = v.csrs;
        inst_clear = v.clr; resp_rdata = v.rdata;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_valid"}, -1, 32'(req_valid), 0);
        chk({tag, "_mem_stall"}, -1, 32'(mem_stall), 0);
        chk({tag, "_pc_next"}, -1, pc_next, 0);
        chk({tag, "_inst_next"}, -1, inst_next, 0);
        chk({tag, "_wb_data"}, -1, wb_data, 0);
        chk({tag, "_ctl"}, -1, 32'({R_wen_next, csr_wen_next, rd_next, misalign, bus_err}), 0);
        chk({tag, "_req"}, -1, req_addr | req_wdata | 32'(req_wstrb) | 32'(req_wen), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: stall-cycle invariants, request fields, then outcome.
    always @(negedge clk) begin
        if (chk_en) begin
            if (mem_stall) begin
                stall_run++;
                chk("stall_R_wen_next", -1, 32'(R_wen_next), 0);
                chk("stall_csr_wen_next", -1, 32'(csr_wen_next), 0);
                if (req_valid && q.size() > 0) begin
                    exp_t e;
                    e = model(q[0].v);
                    chk("req_addr", int'(q[0].v.pc[7:0]), req_addr, e.addr);
                    chk("req_wen", int'(q[0].v.pc[7:0]), 32'(req_wen), 32'(e.store));
                    if (e.store) begin
                        chk("req_wstrb", int'(q[0].v.pc[7:0]), 32'(req_wstrb), 32'(e.strb));
                        chk("req_wdata", int'(q[0].v.pc[7:0]), req_wdata, e.wdata);
                    end
                    if (q[0].v.lit_en) begin
                        chk("lit_req_addr", int'(q[0].v.pc[7:0]), req_addr, q[0].v.lit_addr);
                        if (e.store) begin
                            chk("lit_req_wstrb", int'(q[0].v.pc[7:0]), 32'(req_wstrb), 32'(q[0].v.lit_strb));
                            chk("lit_req_wdata", int'(q[0].v.pc[7:0]), req_wdata, q[0].v.lit_wdata);
                        end
                    end
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                ent_t en;
                exp_t e;
                int id;
                en = q.pop_front();
                e = model(en.v);
                id = int'(en.v.pc[7:0]) / 4;
                chk("pc_next", id, pc_next, en.v.pc);
                chk("inst_next", id, inst_next, en.v.inst);
                chk("csrs_next", id, csrs_next, en.v.csrs);
                chk("rd_next", id, 32'(rd_next), 32'(en.v.rd));
                chk("csr_wen_next", id, 32'(csr_wen_next), en.v.clr ? 0 : 32'(en.v.csr_wen));
                chk("R_wen_next", id, 32'(R_wen_next), 32'(e.rwen));
                chk("misalign", id, 32'(misalign), 32'(e.mis));
                chk("bus_err", id, 32'(bus_err), 32'(e.err));
                chk("stall_cycles", id, stall_run, e.stalls);
                chk("out_req_valid", id, 32'(req_valid), 0);
                if (e.wbchk) chk("wb_data", id, wb_data, e.wb);
                if (en.v.lit_en && !en.v.mwen) chk("lit_wb_data", id, wb_data, en.v.lit_wb);
                stall_run = 0;
            end
        end
    end

    initial begin
        int idx, guard, rdy_cnt, rsp_cnt;
        vec_t v;
        vecs[0]  = mk(3'b000, 1, 0, 0, 32'h0000_1234, 0, 0, 0, 0);              // ADD
        vecs[1]  = mk(3'b000, 1, 0, 1, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 2);  // LB
        vecs[2]  = mk(3'b100, 1, 0, 1, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 2);  // LBU
        vecs[3]  = mk(3'b001, 0, 1, 0, 32'h0000_0102, 32'h0000_ABCD, 32'hDEAD_BEEF, 1, 0); // SH
        vecs[4]  = mk(3'b010, 1, 0, 1, 32'h0000_0101, 0, 32'h1111_1111, 0, 0);  // LW misaligned
        vecs[5]  = mk(3'b001, 1, 0, 1, 32'h0000_0202, 0, 32'h8001_7FFF, 2, 1);  // LH
        vecs[6]  = mk(3'b101, 1, 0, 1, 32'h0000_0202, 0, 32'h8001_7FFF, 0, 0);  // LHU
        vecs[7]  = mk(3'b000, 0, 1, 0, 32'h0000_0303, 32'h0000_005A, 32'hDEAD_BEEF, 0, 1); // SB
        vecs[8]  = mk(3'b010, 0, 1, 0, 32'h0000_0400, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0); // SW
        vecs[9]  = mk(3'b010, 1, 0, 1, 32'h0000_0500, 0, 32'h5555_5555, 0, -1); // LW timeout
        vecs[10] = mk(3'b000, 1, 0, 0, 32'h0000_0077, 0, 0, 0, 0);              // ALU after timeout
        vecs[11] = mk(3'b010, 1, 0, 1, 32'h0000_0600, 0, 32'h1122_3344, 1, 1);  // clear during stall
        vecs[12] = mk(3'b010, 1, 0, 1, 32'h0000_0700, 0, 32'h9999_9999, 0, 0);  // cleared at capture
        vecs[13] = mk(3'b001, 0, 1, 0, 32'h0000_0103, 32'h0000_1234, 0, 0, 0);  // SH misaligned
        vecs[14] = mk(3'b001, 1, 0, 1, 32'h0000_0201, 0, 0, 0, 0);              // LH misaligned
        vecs[15] = mk(3'b000, 1, 0, 1, 32'h8000_0001, 0, 32'h0000_FF00, 0, 0);  // LB byte 1
        vecs[16] = mk(3'b010, 1, 0, 1, 32'h0000_0800, 0, 32'h0BAD_F00D, 2, 4);  // LW at timeout edge
        for (int i = 0; i < N; i++) begin
            vecs[i].pc      = 32'h1000 + 32'(i * 4);
            vecs[i].inst    = 32'h0000_0013 ^ 32'(i << 7);
            vecs[i].rd      = 5'(i + 1);
            vecs[i].csrs    = 32'hC000_0000 + 32'(i);
            vecs[i].csr_wen = 4'(i);
        end
        vecs[0].lit_en = 1; vecs[0].lit_wb = 32'h0000_1234;
        vecs[1].lit_en = 1; vecs[1].lit_wb = 32'hFFFF_FF80; vecs[1].lit_addr = 32'h8000_0000;
        vecs[2].lit_en = 1; vecs[2].lit_wb = 32'h0000_0080; vecs[2].lit_addr = 32'h8000_0000;
        vecs[3].lit_en = 1; vecs[3].lit_addr = 32'h0000_0100;
        vecs[3].lit_strb = 4'b1100; vecs[3].lit_wdata = 32'hABCD_0000;
        vecs[5].lit_en = 1; vecs[5].lit_wb = 32'hFFFF_8001; vecs[5].lit_addr = 32'h0000_0200;
        vecs[11].clr_stall = 1;
        vecs[12].clr = 1;
        bub = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        cur = bub;

        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        apply(bub);
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        idx = 0; guard = 0; rdy_cnt = 0; rsp_cnt = 0;
        while ((idx < N || q.size() > 0) && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
            req_ready = 1'b0;
            resp_valid = 1'b0;
            if (!mem_stall) begin
                if (idx < N) begin
                    v = vecs[idx];
                    q.push_back('{v: v, cyc: cyc});
                    idx++;
                end else begin
                    v = bub;
                end
                apply(v);
                cur = v; rdy_cnt = 0; rsp_cnt = 0;
            end else begin
                if (cur.clr_stall) inst_clear = 1'b1;
                if (req_valid) begin
                    if (rdy_cnt >= cur.rdy) req_ready = 1'b1;
                    else rdy_cnt++;
                end else if (cur.rsp >= 0 && rsp_cnt >= cur.rsp) begin
                    resp_valid = 1'b1;
                end else begin
                    rsp_cnt++;
                end
            end
        end
        if (guard >= 2000) chk("cycle_budget", -1, 32'(guard), 0);

        // Reset arriving while a load sits in WAIT with the bus still active.
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_pre_idle", -1, 32'(mem_stall), 0);
        cur = mk(3'b010, 1, 0, 1, 32'h0000_0900, 0, 32'h7777_7777, 0, -1);
        apply(cur);
        @(posedge clk);
        #2;
        chk("rst_in_req", -1, 32'(req_valid), 1);
        req_ready = 1'b1;
        @(posedge clk);
        #2;
        req_ready = 1'b0;
        chk("rst_in_wait", -1, 32'({mem_stall, req_valid}), 32'b10);
        rst = 1'b1; req_ready = 1'b1; resp_valid = 1'b1;
        @(posedge clk);
        #2;
        chk_zero("rst_wait");
        apply(bub);
        req_ready = 1'b0; resp_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post_rst_idle", -1, 32'({mem_stall, req_valid, R_wen_next}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
